udp_payload_packer: RTL
=======================

# udp_payload_packer

Byte-stream to wide-payload packer in the `clk_200m` domain, sitting directly upstream of `ethernet_test`. It collects application bytes into one of two 120-byte banks (ping-pong). A bank is committed when it is full, on `s_last`, or after an idle timeout. The committed bank is presented on the 961-bit `udp_send_data` bus with `udp_send_data_length`, and `udp_send_data_valid` is held as a level until the synchronised send-acknowledge pulse returns from the Ethernet side.

## Interface
- `MAX_BYTES`, 120: payload bytes per bank.
- `PAYLOAD_W`, 961: width of `udp_send_data`. Bit 960 is always 0.
- `FLUSH_CYCLES`, 1000: consecutive idle cycles that force a partial bank to commit.
- `GAP_CYCLES`, 32: minimum low time of `udp_send_data_valid` after an ack. This lets the rgmii-side synchroniser see the low level.

Ports:
- `clk_200m`  in  1: clock.
- `rstn`  in  1: reset, synchronous, active-low; clock clk_200m.
- `s_data`  in  8: input byte.
- `s_valid`  in  1: byte valid.
- `s_last`  in  1: last byte of message; qualified by `s_valid`.
- `s_ready`  out  1: byte accepted when `s_valid & s_ready`.
- `udp_send_data_valid`  out  1: level; payload pending.
- `udp_send_data`  out  961: payload. Byte k is at bits [8k+7:8k]; unused bytes are 0.
- `udp_send_data_length`  out  16: byte count, 1..`MAX_BYTES`.
- `send_ack`  in  1: one-cycle pulse, the clk_200m-synchronised ready posedge.
- `frames_sent`  out  16: acknowledged-frame counter; wraps 65535→0.

## Operation
- **Reset state (all outputs):**
  - Both banks EMPTY with count 0.
  - `s_ready`=1, `udp_send_data_valid`=0, `udp_send_data`=0, `udp_send_data_length`=0, `frames_sent`=0.
  - Idle and gap counters at 0.
- **Bank states:** EMPTY → FILLING → COMMITTED → SENDING → EMPTY.
  - The fill pointer selects the bank receiving bytes.
  - The send pointer selects the bank being presented.
- **Fill:** each accepted byte is written at index `count`, then `count` increments.
- **Commit conditions** (checked on the accepting or idle edge):
  - `count` reaches `MAX_BYTES`; or
  - the accepted byte carries `s_last`; or
  - `count`>0 and `FLUSH_CYCLES` consecutive cycles pass with no accepted byte.
  - On commit, the fill pointer toggles to the other bank.
- **`s_ready`** is 1 iff the bank under the fill pointer is EMPTY or FILLING. It is derived combinationally from registered state.
- **Sender FSM:**
  - S_IDLE: if a COMMITTED bank exists, load its bytes and count into the output registers, set valid=1, and go to S_VALID.
  - S_VALID: on `send_ack`, set valid=0, increment `frames_sent`, release the bank to EMPTY, and go to S_GAP.
  - S_GAP: after `GAP_CYCLES` cycles, go to S_IDLE.
- **Commit order:** banks are sent in commit order, never reordered.
- **Ack handling:** `send_ack` outside S_VALID is ignored.
- **Simultaneous events:** a commit and an ack in the same cycle are both processed. A bank released by the ack may be refilled starting the next cycle.
- **No empty frames:** a zero-length frame is never committed.

## Timing
- **Byte to commit:** the byte that triggers a commit is accepted at edge N. The bank is COMMITTED after edge N. `s_ready` reflects the next bank's availability in cycle N+1.
- **Commit to valid:** with the sender in S_IDLE, `udp_send_data_valid` rises 1 cycle after commit (edge N+1).
- **Output stability:** data and length are stable from the valid rise until the next valid rise, including the gap.
- **Ack to valid low:** valid drops on the edge after `send_ack` is sampled. The next valid rise is no earlier than `GAP_CYCLES`+1 cycles later.
- **Flush timing:** the idle counter is cleared by every accepted byte. Commit occurs at the edge completing the `FLUSH_CYCLES`-th idle cycle.
- **Full-throughput stall:** with both banks committed or sending, `s_ready`=0 until an ack frees a bank.
- **Reset mid-operation:** the reset state is restored in one edge and any partial or pending frame is discarded.

## Structure
- **Package `udp_tx_pkg`:** holds `MAX_BYTES`, `PAYLOAD_W`, the bank-state enum and the sender-state enum (S_IDLE/S_VALID/S_GAP).
- **Sub-module `udp_payload_bank`:** storage for one bank (120×8 register array, byte count, state), instantiated twice. Top-level logic holds the pointers, the idle/gap counters and the sender FSM.

## Test plan
- **Full bank:** 120 back-to-back bytes 0x00..0x77.
  - Valid rises 1 cycle after the 120th byte; length=120.
  - data[7:0]=0x00, data[959:952]=0x77, bit 960=0.
  - Ack → valid low next cycle, `frames_sent`=1.
- **`s_last`:** 5 bytes 0xA0..0xA4 with `s_last` on the 5th → length=5; bytes 5..119 = 0.
- **Idle flush:** 3 bytes then idle → valid rises at idle cycle 1000+1; length=3. With no ack, valid stays high indefinitely.
- **Backpressure:** 360 bytes offered continuously, ack withheld.
  - `s_ready` falls after 240 bytes are accepted.
  - First ack → second frame's valid rises 33 cycles later; `s_ready` returns to 1; frames are delivered in order.
- **Reset mid-frame:** 50 bytes, then `rstn`=0 for 1 cycle.
  - All outputs return to their reset values.
  - The next 120 bytes form a frame with byte 0 equal to the first post-reset byte.
- **Ack while idle:** `send_ack` pulsed while valid=0 → no state change, `frames_sent` unchanged.

Source files
------------

// File: rtl/udp_payload_packer_pkg.sv
// udp_tx_pkg: shared sizes and state encodings for the UDP payload packer.
//   MAX_BYTES    payload bytes held by one bank
//   PAYLOAD_W    width of the udp_send_data bus (top bit always 0)
//   DATA_W       bits of real payload storage per bank
//   CNT_W        width of a bank byte count (0..MAX_BYTES)
//   bank_state_e per-bank lifecycle
//   send_state_e sender FSM states
package udp_tx_pkg;

  localparam int MAX_BYTES = 120;
  localparam int PAYLOAD_W = 961;
  localparam int DATA_W    = MAX_BYTES * 8;
  localparam int CNT_W     = $clog2(MAX_BYTES + 1);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_COMMITTED,
    BANK_SENDING
  } bank_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_VALID,
    S_GAP
  } send_state_e;

endpackage

// File: rtl/udp_payload_packer_if.sv
// udp_payload_packer_if: byte-stream input and wide-payload output of the packer.
//   s_data/s_valid/s_last/s_ready  byte stream, accepted on s_valid & s_ready
//   udp_send_data_valid            level, payload pending
//   udp_send_data                  payload, byte k at [8k+7:8k]
//   udp_send_data_length           byte count of the presented payload
//   send_ack                       one-cycle acknowledge from the Ethernet side
// master = producer/consumer around the packer, slave = the packer itself.
interface udp_payload_packer_if;
  import udp_tx_pkg::*;

  logic [7:0]           s_data;
  logic                 s_valid;
  logic                 s_last;
  logic                 s_ready;
  logic                 udp_send_data_valid;
  logic [PAYLOAD_W-1:0] udp_send_data;
  logic [15:0]          udp_send_data_length;
  logic                 send_ack;

  modport master (
    output s_data, s_valid, s_last, send_ack,
    input  s_ready, udp_send_data_valid, udp_send_data, udp_send_data_length
  );

  modport slave (
    input  s_data, s_valid, s_last, send_ack,
    output s_ready, udp_send_data_valid, udp_send_data, udp_send_data_length
  );

endinterface

// File: rtl/udp_payload_packer_bank.sv
// udp_payload_bank: one payload bank (MAX_BYTES x 8 storage, byte count, state).
//   clk_200m, rstn  clock, synchronous active-low reset
//   wr_en, wr_data  append one byte at index count
//   commit          bank becomes COMMITTED (may coincide with wr_en)
//   take            COMMITTED -> SENDING
//   free_bank       SENDING -> EMPTY, count cleared
//   state, count    current bank state and byte count
//   payload         stored bytes, bytes at index >= count forced to 0
module udp_payload_bank
  import udp_tx_pkg::*;
(
  input  logic              clk_200m,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              commit,
  input  logic              take,
  input  logic              free_bank,
  output bank_state_e       state,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] payload
);

  logic [7:0] mem [MAX_BYTES];

  // Storage is not reset: stale bytes beyond count are masked on the way out.
  always_ff @(posedge clk_200m) begin
    if (wr_en) mem[count] <= wr_data;
  end

  always_ff @(posedge clk_200m) begin
    if (!rstn) begin
      state <= BANK_EMPTY;
      count <= '0;
    end else begin
      if (wr_en) begin
        count <= count + 1'b1;
        if (state == BANK_EMPTY) state <= BANK_FILLING;
      end
      if (commit)    state <= BANK_COMMITTED;
      if (take)      state <= BANK_SENDING;
      if (free_bank) begin
        state <= BANK_EMPTY;
        count <= '0;
      end
    end
  end

  always_comb begin
    payload = '0;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (CNT_W'(k) < count) payload[8*k +: 8] = mem[k];
    end
  end

endmodule

// File: rtl/udp_payload_packer.sv
// udp_payload_packer: packs a byte stream into two ping-pong 120-byte banks and
// presents each committed bank as one wide payload until acknowledged.
//   clk_200m     clock
//   rstn         synchronous active-low reset
//   bus          udp_payload_packer_if.slave (byte stream in, payload out)
//   frames_sent  count of acknowledged frames, wraps at 16 bits
//
// Sender FSM
//   state   | meaning
//   S_IDLE  | waiting for the bank under send_ptr to be COMMITTED
//   S_VALID | payload presented, valid high, waiting for send_ack
//   S_GAP   | valid held low for GAP_CYCLES so the far-side synchroniser sees it
module udp_payload_packer
  import udp_tx_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1000,
  parameter int GAP_CYCLES   = 32
) (
  input  logic                clk_200m,
  input  logic                rstn,
  udp_payload_packer_if.slave bus,
  output logic [15:0]         frames_sent
);

  localparam int IDLE_W = $clog2(FLUSH_CYCLES + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

  logic              fill_ptr;
  logic              send_ptr;
  bank_state_e       bank_state   [2];
  logic [CNT_W-1:0]  bank_count   [2];
  logic [DATA_W-1:0] bank_payload [2];
  logic [1:0]        bank_wr;
  logic [1:0]        bank_commit;
  logic [1:0]        bank_take;
  logic [1:0]        bank_free;

  bank_state_e       fill_state;
  logic [CNT_W-1:0]  fill_count;
  logic              fill_open;
  logic              accept;
  logic              commit_fill;
  logic [IDLE_W-1:0] idle_cnt;

  send_state_e       state_q, state_d;
  logic              load;
  logic              ack_take;
  logic [GAP_W-1:0]  gap_cnt;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [15:0]       len_q;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    udp_payload_bank u_bank (
      .clk_200m  (clk_200m),
      .rstn      (rstn),
      .wr_en     (bank_wr[b]),
      .wr_data   (bus.s_data),
      .commit    (bank_commit[b]),
      .take      (bank_take[b]),
      .free_bank (bank_free[b]),
      .state     (bank_state[b]),
      .count     (bank_count[b]),
      .payload   (bank_payload[b])
    );
  end

  // Fill side: a commit fires either with the byte that fills/ends the bank,
  // or on the edge that completes the FLUSH_CYCLES-th idle cycle.
  always_comb begin
    fill_state  = bank_state[fill_ptr];
    fill_count  = bank_count[fill_ptr];
    fill_open   = (fill_state == BANK_EMPTY) || (fill_state == BANK_FILLING);
    accept      = bus.s_valid && fill_open;
    commit_fill = 1'b0;
    if (accept) begin
      commit_fill = (fill_count == CNT_W'(MAX_BYTES - 1)) || bus.s_last;
    end else if ((fill_state == BANK_FILLING) && (fill_count != '0)) begin
      commit_fill = (idle_cnt == IDLE_W'(FLUSH_CYCLES - 1));
    end
  end

  assign bus.s_ready = fill_open;

  always_comb begin
    bank_wr     = '0;
    bank_commit = '0;
    bank_take   = '0;
    bank_free   = '0;
    for (int b = 0; b < 2; b++) begin
      bank_wr[b]     = accept      && (fill_ptr == 1'(b));
      bank_commit[b] = commit_fill && (fill_ptr == 1'(b));
      bank_take[b]   = load        && (send_ptr == 1'(b));
      bank_free[b]   = ack_take    && (send_ptr == 1'(b));
    end
  end

  always_ff @(posedge clk_200m) begin
    if (!rstn) begin
      fill_ptr <= 1'b0;
      idle_cnt <= '0;
    end else begin
      if (commit_fill) fill_ptr <= ~fill_ptr;
      if (accept || commit_fill || (fill_state != BANK_FILLING)) idle_cnt <= '0;
      else                                                       idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Sender FSM. Banks alternate, so following send_ptr preserves commit order.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    ack_take = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bank_state[send_ptr] == BANK_COMMITTED) begin
          load    = 1'b1;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (bus.send_ack) begin
          ack_take = 1'b1;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_200m) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      send_ptr    <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      len_q       <= '0;
      gap_cnt     <= '0;
      frames_sent <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        valid_q <= 1'b1;
        data_q  <= bank_payload[send_ptr];
        len_q   <= 16'(bank_count[send_ptr]);
      end
      // Gap timer is a down-counter loaded on ack; S_GAP ends at terminal count.
      if (ack_take) begin
        valid_q     <= 1'b0;
        frames_sent <= frames_sent + 16'd1;
        send_ptr    <= ~send_ptr;
        gap_cnt     <= GAP_W'(GAP_CYCLES - 1);
      end else if ((state_q == S_GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  assign bus.udp_send_data_valid  = valid_q;
  assign bus.udp_send_data        = {1'b0, data_q};
  assign bus.udp_send_data_length = len_q;

endmodule
